// File: rtl/ps2_kbd_if.sv
// Bridge-side I/O bus between the system bridge (master) and the PS/2 keyboard controller (slave).
interface ps2_kbd_if;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_rdata;
  logic        io_ack;

  modport master (output io_addr, io_wdata, io_rd, io_wr, input io_rdata, io_ack);
  modport slave  (input io_addr, io_wdata, io_rd, io_wr, output io_rdata, io_ack);
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver with scan-code FIFO and DATA/STATUS/CTRL I/O registers.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_kbd_ctrl #(
  parameter logic [15:0] IO_BASE    = 16'h0060,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TIMEOUT    = 20000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  ps2_kbd_if.slave io,
  output logic     irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  // state  | meaning
  // IDLE   | wait for start bit; DATA | shift 8 bits LSB first; PARITY | parity bit; STOP | stop bit, push
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  pclk_sync_q, pdat_sync_q;
  logic        pclk_prev_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        fall, sample, push, set_perr, set_ferr;

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d, ien_q, ien_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, irq_q;
  logic        not_empty, full, hit_dat, hit_sts, hit_ctl, hit, pop, push_ok, flush, clr;
  logic [7:0]  count8;
  logic        unused_wdata;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_sync_q <= 2'b11;
      pdat_sync_q <= 2'b11;
      pclk_prev_q <= 1'b1;
    end else begin
      pclk_sync_q <= {pclk_sync_q[0], ps2_clk};
      pdat_sync_q <= {pdat_sync_q[0], ps2_data};
      pclk_prev_q <= pclk_sync_q[1];
    end
  end

  assign fall   = pclk_prev_q & ~pclk_sync_q[1];
  assign sample = pdat_sync_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    set_perr  = 1'b0;
    set_ferr  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    tmo_d = (state_q == S_IDLE || fall) ? TW'(TIMEOUT) : ((tmo_q != '0) ? tmo_q - 1'b1 : tmo_q);
    if (fall) begin
      unique case (state_q)
        S_IDLE: if (!sample) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
        S_DATA: begin
          shift_d   = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = sample;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!sample) set_ferr = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          else if (^{shift_q, par_q}) push = 1'b1;
          else set_perr = 1'b1;
`else
          else push = 1'b1;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == '0) begin
      state_d = S_IDLE;
    end
  end

  assign count     = wptr_q - rptr_q;
  assign count8    = 8'(count);
  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign hit_dat   = (io.io_addr == IO_BASE);
  assign hit_sts   = (io.io_addr == IO_BASE + 16'd1);
  assign hit_ctl   = (io.io_addr == IO_BASE + 16'd2);
  assign hit       = hit_dat | hit_sts | hit_ctl;
  assign pop       = io.io_rd & hit_dat & not_empty;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok   = push & (~full | pop);
  assign flush     = io.io_wr & hit_ctl & io.io_wdata[2];
  assign clr       = io.io_wr & hit_ctl & io.io_wdata[1];
  assign unused_wdata = ^io.io_wdata[15:3];

  always_comb begin
    wptr_d = wptr_q + (AW+1)'(push_ok);
    rptr_d = rptr_q + (AW+1)'(pop);
    if (flush) rptr_d = wptr_d;
    ovf_d  = clr ? 1'b0 : ovf_q;
    perr_d = clr ? 1'b0 : perr_q;
    ferr_d = clr ? 1'b0 : ferr_q;
    if (push & full & ~pop) ovf_d = 1'b1;
    if (set_perr) perr_d = 1'b1;
    if (set_ferr) ferr_d = 1'b1;
    ien_d = (io.io_wr & hit_ctl) ? io.io_wdata[0] : ien_q;
    rdata_d = rdata_q;
    if (io.io_rd) begin
      if (hit_dat) rdata_d = not_empty ? {8'h00, mem_q[rptr_q[AW-1:0]]} : 16'h0000;
      else if (hit_sts) rdata_d = {count8, 3'b000, ferr_q, perr_q, ovf_q, full, not_empty};
      else if (hit_ctl) rdata_d = {15'h0000, ien_q};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      tmo_q     <= TW'(TIMEOUT);
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ien_q     <= 1'b0;
      rdata_q   <= 16'h0000;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ien_q     <= ien_d;
      rdata_q   <= rdata_d;
      ack_q     <= (io.io_rd | io.io_wr) & hit;
      irq_q     <= ien_q & not_empty;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  assign io.io_rdata = rdata_q;
  assign io.io_ack   = ack_q;
  assign irq         = irq_q;
endmodule
